// File: rtl/qerv_pkg.sv
// Shared types and helpers for the qerv load/store sequencer.
// Holds the sequencer state enum, size/command encodings and byte-lane helpers.
package qerv_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        BUS  = 3'd2,
        WB   = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic CMD_LOAD  = 1'b0;
    localparam logic CMD_STORE = 1'b1;

    // Size code 3 behaves exactly like a word access.
    function automatic logic [1:0] f_norm_size(input logic [1:0] size);
        return (size == 2'd3) ? SZ_WORD : size;
    endfunction

    // A half needs an even address, a word needs a zero offset.
    function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lsb[0];
            default: return (lsb != 2'd0);
        endcase
    endfunction

    // Drop the offset bits that the access size cannot honour.
    function automatic logic [1:0] f_align_lsb(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SZ_BYTE: return lsb;
            SZ_HALF: return {lsb[1], 1'b0};
            default: return 2'd0;
        endcase
    endfunction

    // Byte enables on the data bus for a given size and lane offset.
    function automatic logic [3:0] f_byte_sel(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SZ_BYTE: return 4'b0001 << lsb;
            SZ_HALF: return 4'b0011 << {lsb[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/qerv_bitcnt.sv
// Bit position counter shared by the init and writeback shift phases.
// Steps by BITS_PER_CYCLE and wraps to zero naturally after the last position.
module qerv_bitcnt #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clr,
    input  logic       i_en,
    output logic [4:0] o_cnt,
    output logic       o_done
);

    localparam logic [4:0] STEP = 5'(BITS_PER_CYCLE);
    localparam logic [4:0] LAST = 5'(32 - BITS_PER_CYCLE);

    logic [4:0] r_cnt;

    // Advance the bit position while a shift phase is active, otherwise hold at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 5'd0;
        end else if (i_clr) begin
            r_cnt <= 5'd0;
        end else if (i_en) begin
            r_cnt <= r_cnt + STEP;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_done = i_en && (r_cnt == LAST);

endmodule

// File: rtl/qerv_mem_seq.sv
// Load/store sequencer for the qerv buffer register: init shift, one bus
// transaction, then writeback shift for loads.
// Optional feature: define QERV_MISALIGN_TRAP_EN to trap misaligned accesses
// instead of silently aligning them.
module qerv_mem_seq
    import qerv_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req,
    input  logic       i_cmd,
    input  logic [1:0] i_size,
    input  logic [1:0] i_addr_lsb,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_trap,
    output logic       o_init,
    output logic       o_en,
    output logic [4:0] o_cnt,
    output logic       o_cnt_done,
    output logic [1:0] o_lsb,
    output logic       o_byte_valid,
    output logic       o_load,
    output logic       o_dbus_cyc,
    output logic       o_dbus_we,
    output logic [3:0] o_dbus_sel,
    input  logic       i_dbus_ack
);

    state_t     r_state;
    logic       r_cmd;
    logic [1:0] r_size;
    logic [1:0] r_lsb;
    logic       r_dbus_cyc;
    logic       r_dbus_we;
    logic [3:0] r_dbus_sel;
`ifdef QERV_MISALIGN_TRAP_EN
    logic       r_trap;
`endif

    logic       w_shift;
    logic       w_cnt_done;
    logic [4:0] w_cnt;
    logic [1:0] w_size;
    logic [1:0] w_byte_idx;

    assign w_shift = (r_state == INIT) || (r_state == WB);
    assign w_size  = f_norm_size(i_size);

    qerv_bitcnt #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_bitcnt (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_clr  (!w_shift),
        .i_en   (w_shift),
        .o_cnt  (w_cnt),
        .o_done (w_cnt_done)
    );

    // Sequencer FSM: latches the request and owns the registered bus handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_cmd      <= 1'b0;
            r_size     <= 2'd0;
            r_lsb      <= 2'd0;
            r_dbus_cyc <= 1'b0;
            r_dbus_we  <= 1'b0;
            r_dbus_sel <= 4'd0;
`ifdef QERV_MISALIGN_TRAP_EN
            r_trap     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req) begin
                        r_cmd  <= i_cmd;
                        r_size <= w_size;
`ifdef QERV_MISALIGN_TRAP_EN
                        r_lsb  <= i_addr_lsb;
                        if (f_misaligned(w_size, i_addr_lsb)) begin
                            r_trap  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_trap  <= 1'b0;
                            r_state <= INIT;
                        end
`else
                        r_lsb   <= f_align_lsb(w_size, i_addr_lsb);
                        r_state <= INIT;
`endif
                    end
                end
                INIT: begin
                    if (w_cnt_done) begin
                        r_dbus_cyc <= 1'b1;
                        r_dbus_we  <= r_cmd;
                        r_dbus_sel <= f_byte_sel(r_size, r_lsb);
                        r_state    <= BUS;
                    end
                end
                BUS: begin
                    if (i_dbus_ack) begin
                        r_dbus_cyc <= 1'b0;
                        r_dbus_we  <= 1'b0;
                        r_dbus_sel <= 4'd0;
                        r_state    <= (r_cmd == CMD_STORE) ? DONE : WB;
                    end
                end
                WB: begin
                    if (w_cnt_done) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
`ifdef QERV_MISALIGN_TRAP_EN
                    r_trap  <= 1'b0;
`endif
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_byte_idx = w_cnt[4:3];

    // Status and buffer controls decoded from the registered state.
    always_comb begin
        o_busy       = (r_state != IDLE);
        o_done       = (r_state == DONE);
        o_init       = (r_state == INIT);
        o_en         = w_shift;
        o_cnt        = w_cnt;
        o_cnt_done   = w_cnt_done;
        o_lsb        = r_lsb;
        o_dbus_cyc   = r_dbus_cyc;
        o_dbus_we    = r_dbus_we;
        o_dbus_sel   = r_dbus_sel;
        o_load       = (r_state == BUS) && i_dbus_ack && (r_cmd == CMD_LOAD);
        o_byte_valid = (r_state == WB) &&
                       ((w_byte_idx == 2'd0) ||
                        ((w_byte_idx == 2'd1) && (r_size != SZ_BYTE)) ||
                        (r_size == SZ_WORD));
`ifdef QERV_MISALIGN_TRAP_EN
        o_trap       = r_trap && (r_state == DONE);
`else
        o_trap       = 1'b0;
`endif
    end

endmodule

// File: tb/tb_qerv_mem_seq.sv
// Scoreboard bench for qerv_mem_seq with BITS_PER_CYCLE=2 (16-cycle shift phases).
// Stimulus pushes hand-computed transaction summaries; a monitor tallies what the
// DUT does and compares on every o_done.
module tb_qerv_mem_seq;

    localparam int W = 2;

    typedef struct {
        int         doneLat;
        bit         trap;
        bit         bus;
        logic [3:0] sel;
        bit         we;
        int         loads;
        int         loadLat;
        int         bv;
        int         wb;
        logic [1:0] lsb;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_req = 1'b0;
    logic       i_cmd = 1'b0;
    logic [1:0] i_size = 2'd0;
    logic [1:0] i_addr_lsb = 2'd0;
    logic       i_dbus_ack = 1'b0;
    logic       o_busy, o_done, o_trap, o_init, o_en, o_cnt_done;
    logic       o_byte_valid, o_load, o_dbus_cyc, o_dbus_we;
    logic [4:0] o_cnt;
    logic [1:0] o_lsb;
    logic [3:0] o_dbus_sel;

    exp_t sbQ[$];
    exp_t monExp;
    int   compared = 0;
    int   mismatched = 0;
    int   cycleNum = 0;
    int   strayDone = 0;
    int   ackWait = 0;
    int   waitCnt = 0;
    bit   spurious = 1'b0;

    int         acceptCycle = 0;
    bit         busSeen = 1'b0;
    logic [3:0] selSeen = 4'd0;
    bit         weSeen = 1'b0;
    int         loadCnt = 0;
    int         loadLat = -1;
    int         bvCnt = 0;
    int         wbCnt = 0;

    qerv_mem_seq #(.BITS_PER_CYCLE(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (i_req),
        .i_cmd       (i_cmd),
        .i_size      (i_size),
        .i_addr_lsb  (i_addr_lsb),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_trap      (o_trap),
        .o_init      (o_init),
        .o_en        (o_en),
        .o_cnt       (o_cnt),
        .o_cnt_done  (o_cnt_done),
        .o_lsb       (o_lsb),
        .o_byte_valid(o_byte_valid),
        .o_load      (o_load),
        .o_dbus_cyc  (o_dbus_cyc),
        .o_dbus_we   (o_dbus_we),
        .o_dbus_sel  (o_dbus_sel),
        .i_dbus_ack  (i_dbus_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleNum <= cycleNum + 1;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clearTally();
        busSeen = 1'b0;
        selSeen = 4'd0;
        weSeen  = 1'b0;
        loadCnt = 0;
        loadLat = -1;
        bvCnt   = 0;
        wbCnt   = 0;
    endtask

    // Bus slave: acks after ackWait BUS cycles; outside BUS drives optional spurious acks.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (o_dbus_cyc) begin
                i_dbus_ack = (waitCnt == ackWait);
                waitCnt++;
            end else begin
                i_dbus_ack = spurious;
                waitCnt = 0;
            end
        end
    end

    // Monitor: tally DUT behaviour per transaction and score it on o_done.
    always @(negedge clk) begin
        if (!rst_n) begin
            clearTally();
        end else begin
            if (i_req && !o_busy) acceptCycle = cycleNum;
            if (o_dbus_cyc && !busSeen) begin
                busSeen = 1'b1;
                selSeen = o_dbus_sel;
                weSeen  = o_dbus_we;
            end
            if (o_load) begin
                loadCnt++;
                loadLat = cycleNum - acceptCycle;
            end
            if (o_en && !o_init) wbCnt++;
            if (o_byte_valid) bvCnt++;
            if (o_done) begin
                if (sbQ.size() == 0) begin
                    strayDone++;
                end else begin
                    monExp = sbQ.pop_front();
                    check("done_latency", cycleNum - acceptCycle, monExp.doneLat);
                    check("trap", int'(o_trap), int'(monExp.trap));
                    check("bus_seen", int'(busSeen), int'(monExp.bus));
                    check("dbus_sel", int'(selSeen), int'(monExp.sel));
                    check("dbus_we", int'(weSeen), int'(monExp.we));
                    check("load_pulses", loadCnt, monExp.loads);
                    if (monExp.loads > 0) check("load_cycle", loadLat, monExp.loadLat);
                    check("byte_valid_cycles", bvCnt, monExp.bv);
                    check("wb_cycles", wbCnt, monExp.wb);
                    check("lsb", int'(o_lsb), int'(monExp.lsb));
                end
                clearTally();
            end
        end
    end

    // Issue one request (nReq identical back-to-back transactions while i_req stays high).
    task automatic applyStimulus(input bit cmd, input logic [1:0] size, input logic [1:0] lsb,
                                 input int aw, input int nReq, input exp_t e);
        for (int k = 0; k < nReq; k++) sbQ.push_back(e);
        ackWait    = aw;
        i_cmd      = cmd;
        i_size     = size;
        i_addr_lsb = lsb;
        i_req      = 1'b1;
        for (int i = 0; i < 400 && sbQ.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_timeout", sbQ.size(), 0);
        sbQ.delete();
        i_req = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        check({tag, "_busy"}, int'(o_busy), 0);
        check({tag, "_done"}, int'(o_done), 0);
        check({tag, "_cyc"}, int'(o_dbus_cyc), 0);
        check({tag, "_sel"}, int'(o_dbus_sel), 0);
        check({tag, "_lsb"}, int'(o_lsb), 0);
        check({tag, "_cnt"}, int'(o_cnt), 0);
        check({tag, "_en"}, int'(o_en), 0);
        check({tag, "_trap"}, int'(o_trap), 0);
    endtask

    initial begin
        #2;
        checkOutput("reset");
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Word load, lsb 0, ack after 3 wait cycles: load at N+4=20, done at 2N+5=37.
        applyStimulus(1'b0, 2'd2, 2'd0, 3, 1,
            '{doneLat:37, trap:0, bus:1, sel:4'hF, we:0, loads:1, loadLat:20, bv:16, wb:16, lsb:2'd0});

        // Byte store, lsb 2, immediate ack: done at N+2=18, no writeback.
        applyStimulus(1'b1, 2'd0, 2'd2, 0, 1,
            '{doneLat:18, trap:0, bus:1, sel:4'b0100, we:1, loads:0, loadLat:0, bv:0, wb:0, lsb:2'd2});

        // Half load, lsb 2, one wait: byte_valid for cnt 0..14 only (8 cycles).
        applyStimulus(1'b0, 2'd1, 2'd2, 1, 1,
            '{doneLat:35, trap:0, bus:1, sel:4'b1100, we:0, loads:1, loadLat:18, bv:8, wb:16, lsb:2'd2});

        // Misaligned half load, lsb 1.
`ifdef QERV_MISALIGN_TRAP_EN
        applyStimulus(1'b0, 2'd1, 2'd1, 0, 1,
            '{doneLat:1, trap:1, bus:0, sel:4'd0, we:0, loads:0, loadLat:0, bv:0, wb:0, lsb:2'd1});
`else
        applyStimulus(1'b0, 2'd1, 2'd1, 0, 1,
            '{doneLat:34, trap:0, bus:1, sel:4'b0011, we:0, loads:1, loadLat:17, bv:8, wb:16, lsb:2'd0});
`endif

        // Spurious acks in IDLE must not start anything or pulse o_load.
        spurious = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("spurious_idle_busy", int'(o_busy), 0);
        check("spurious_idle_load", int'(o_load), 0);

        // Size code 3 load with acks held high through INIT: only the BUS ack counts.
        applyStimulus(1'b0, 2'd3, 2'd0, 2, 1,
            '{doneLat:36, trap:0, bus:1, sel:4'hF, we:0, loads:1, loadLat:19, bv:16, wb:16, lsb:2'd0});
        spurious = 1'b0;

        // Request held through DONE: second transaction starts only from the next IDLE.
        applyStimulus(1'b0, 2'd0, 2'd3, 0, 2,
            '{doneLat:34, trap:0, bus:1, sel:4'b1000, we:0, loads:1, loadLat:17, bv:4, wb:16, lsb:2'd3});

        // Reset in the middle of a stalled bus cycle.
        ackWait    = 1000;
        i_cmd      = 1'b1;
        i_size     = 2'd2;
        i_addr_lsb = 2'd0;
        i_req      = 1'b1;
        for (int i = 0; i < 60 && !o_dbus_cyc; i++) @(negedge clk);
        check("reset_test_bus_reached", int'(o_dbus_cyc), 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_cyc_drop", int'(o_dbus_cyc), 0);
        i_req = 1'b0;
        checkOutput("midreset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        ackWait = 0;
        repeat (5) @(posedge clk);
        #1;
        check("post_reset_busy", int'(o_busy), 0);
        check("stray_done", strayDone, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
